// File: rtl/adc_conv_ctrl.sv
// Ramp / successive-approximation ADC conversion controller driving a PWM-DAC trial code
// against an external comparator. Define ADC_AVG_EN to publish the average of every 4 results.
module adc_conv_ctrl #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned SETTLE_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            ADC_sel,
   input  logic                  successive_approx,
   input  logic [1:0]            comp_in,
   output logic [DATA_WIDTH-1:0] dac_code,
   output logic [DATA_WIDTH-1:0] sample,
   output logic                  sample_valid,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [DATA_WIDTH-1:0] MSB = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`ifdef ADC_AVG_EN
   localparam int unsigned ACC_W = DATA_WIDTH + 2;
`endif

   typedef enum logic [2:0] {S_IDLE, S_START, S_SETTLE, S_DECIDE, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] dac_nxt, mask, mask_nxt, sample_nxt, trial_d, result_c;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  conv_sar, sar_nxt;
   logic [1:0]            sel_q;
   logic                  mode_q;
   logic [1:0]            sync1, sync2;
   logic                  cmp, chan_ok, changed, abort, valid_nxt, busy_nxt;
`ifdef ADC_AVG_EN
   logic [ACC_W-1:0]      acc, acc_nxt, acc_sum;
   logic [1:0]            avg_cnt, avg_cnt_nxt;
`endif

   // Selected synchronized comparator bit
   always_comb begin
      cmp = 1'b0;
      case (ADC_sel)
         2'd1:    cmp = sync2[0];
         2'd2:    cmp = sync2[1];
         default: cmp = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      dac_nxt    = dac_code;
      mask_nxt   = mask;
      cnt_nxt    = cnt;
      sar_nxt    = conv_sar;
      sample_nxt = sample;
      valid_nxt  = 1'b0;
      trial_d    = '0;
      result_c   = '0;
`ifdef ADC_AVG_EN
      acc_nxt     = acc;
      avg_cnt_nxt = avg_cnt;
      acc_sum     = '0;
`endif
      chan_ok = (ADC_sel == 2'd1) || (ADC_sel == 2'd2);
      changed = (ADC_sel != sel_q) || (successive_approx != mode_q);
      abort   = (state != S_IDLE) && changed;

      case (state)
         S_IDLE:   if (chan_ok) state_nxt = S_START;
         S_START: begin
            state_nxt = S_SETTLE;
            cnt_nxt   = '0;
         end
         S_SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = S_DECIDE;
            else                                  cnt_nxt   = cnt + CNT_W'(1);
         end
         S_DECIDE: begin
            cnt_nxt = '0;
            if (conv_sar) begin
               trial_d = cmp ? dac_code : (dac_code & ~mask);
               if (mask[0]) begin
                  dac_nxt   = trial_d;
                  result_c  = trial_d;
                  state_nxt = S_DONE;
               end else begin
                  mask_nxt  = mask >> 1;
                  dac_nxt   = trial_d | (mask >> 1);
                  state_nxt = S_SETTLE;
               end
            end else begin
               // Ramp stops at the first code the input does not exceed, or at full scale
               if (!cmp || (dac_code == '1)) begin
                  result_c  = dac_code;
                  state_nxt = S_DONE;
               end else begin
                  dac_nxt   = dac_code + DATA_WIDTH'(1);
                  state_nxt = S_SETTLE;
               end
            end
         end
         S_DONE:   state_nxt = chan_ok ? S_START : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase

      if (abort) begin
         state_nxt = chan_ok ? S_START : S_IDLE;
`ifdef ADC_AVG_EN
         acc_nxt     = '0;
         avg_cnt_nxt = '0;
`endif
      end

      if (state_nxt == S_DONE) begin
`ifdef ADC_AVG_EN
         acc_sum = acc + ACC_W'(result_c);
         if (avg_cnt == 2'd3) begin
            sample_nxt  = DATA_WIDTH'(acc_sum >> 2);
            valid_nxt   = 1'b1;
            acc_nxt     = '0;
            avg_cnt_nxt = '0;
         end else begin
            acc_nxt     = acc_sum;
            avg_cnt_nxt = avg_cnt + 2'd1;
         end
`else
         sample_nxt = result_c;
         valid_nxt  = 1'b1;
`endif
      end

      if (state_nxt == S_START) begin
         sar_nxt  = successive_approx;
         mask_nxt = MSB;
         dac_nxt  = successive_approx ? MSB : '0;
         cnt_nxt  = '0;
      end
      if (state_nxt == S_IDLE) dac_nxt = '0;

      busy_nxt = (state_nxt == S_START) || (state_nxt == S_SETTLE) || (state_nxt == S_DECIDE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         dac_code     <= '0;
         mask         <= '0;
         cnt          <= '0;
         conv_sar     <= 1'b0;
         sel_q        <= 2'd0;
         mode_q       <= 1'b0;
         sync1        <= 2'd0;
         sync2        <= 2'd0;
         sample       <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
`ifdef ADC_AVG_EN
         acc          <= '0;
         avg_cnt      <= 2'd0;
`endif
      end else begin
         state        <= state_nxt;
         dac_code     <= dac_nxt;
         mask         <= mask_nxt;
         cnt          <= cnt_nxt;
         conv_sar     <= sar_nxt;
         sel_q        <= ADC_sel;
         mode_q       <= successive_approx;
         sync1        <= comp_in;
         sync2        <= sync1;
         sample       <= sample_nxt;
         sample_valid <= valid_nxt;
         busy         <= busy_nxt;
`ifdef ADC_AVG_EN
         acc          <= acc_nxt;
         avg_cnt      <= avg_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Directed bench for adc_conv_ctrl (DATA_WIDTH 8, SETTLE_CYCLES 4) with a behavioural comparator.
module tb_adc_conv_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] ADC_sel;
   logic       successive_approx;
   logic [1:0] comp_in;
   logic [7:0] dac_code;
   logic [7:0] sample;
   logic       sample_valid;
   logic       busy;

   logic [7:0] thr;
   logic       half;
   logic       stuck;
   logic       cmp_m;

   int checks = 0;
   int errors = 0;
   int c, nval, first_c, ntr, wraps;
   logic [7:0] prev;
   logic [7:0] trials [5];

   adc_conv_ctrl #(.DATA_WIDTH(8), .SETTLE_CYCLES(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .ADC_sel          (ADC_sel),
      .successive_approx(successive_approx),
      .comp_in          (comp_in),
      .dac_code         (dac_code),
      .sample           (sample),
      .sample_valid     (sample_valid),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   // Analog level = thr (ramp runs) or thr + 1/2 LSB (half=1, SAR runs); unselected channel inverted
   assign cmp_m   = stuck ? 1'b1 : (half ? (dac_code <= thr) : (thr > dac_code));
   assign comp_in = (ADC_sel == 2'd2) ? {cmp_m, ~cmp_m} : {~cmp_m, cmp_m};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) break;
      end
      check("busy_at_start", 32'(busy), 32'd1);
   endtask

   // Counts cycles from the START cycle to the sample_valid cycle
   task automatic run_to_valid(input int budget, output int cyc);
      cyc   = 0;
      prev  = dac_code;
      trials[0] = dac_code;
      ntr   = 1;
      wraps = 0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (dac_code < prev) wraps++;
         if (dac_code != prev && ntr < 5) begin
            trials[ntr] = dac_code;
            ntr++;
         end
         prev = dac_code;
         if (sample_valid) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ADC_sel = 2'd0; successive_approx = 1'b0;
      thr = 8'h00; half = 1'b0; stuck = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dac",   32'(dac_code),     32'h0);
      check("rst_sample",32'(sample),       32'h0);
      check("rst_valid", 32'(sample_valid), 32'h0);
      check("rst_busy",  32'(busy),         32'h0);
      reset = 1'b0;
      @(negedge clk);

`ifdef ADC_AVG_EN
      successive_approx = 1'b1; half = 1'b1; thr = 8'h10; ADC_sel = 2'd1;
      wait_start();
      check("avg_start_dac", 32'(dac_code), 32'h80);
      nval = 0; first_c = -1;
      for (int k = 1; k <= 170; k++) begin
         @(negedge clk);
         if (k == 42)  thr = 8'h11;
         if (k == 84)  thr = 8'h12;
         if (k == 126) thr = 8'h14;
         if (sample_valid) begin
            nval++;
            if (first_c < 0) first_c = k;
         end
      end
      check("avg_valid_count", 32'(nval),    32'd1);
      check("avg_valid_cycle", 32'(first_c), 32'd167);
      check("avg_sample",      32'(sample),  32'h11);
      reset = 1'b1;
      @(negedge clk);
      check("rst2_dac",    32'(dac_code),     32'h0);
      check("rst2_sample", 32'(sample),       32'h0);
      check("rst2_valid",  32'(sample_valid), 32'h0);
      check("rst2_busy",   32'(busy),         32'h0);
      reset = 1'b0;
`else
      // SAR on channel 1
      successive_approx = 1'b1; half = 1'b1; thr = 8'h5A; ADC_sel = 2'd1;
      wait_start();
      run_to_valid(100, c);
      check("sar_latency", 32'(c),      32'd41);
      check("sar_sample",  32'(sample), 32'h5A);
      check("sar_trial0",  32'(trials[0]), 32'h80);
      check("sar_trial1",  32'(trials[1]), 32'h40);
      check("sar_trial2",  32'(trials[2]), 32'h60);
      check("sar_trial3",  32'(trials[3]), 32'h50);
      check("sar_trial4",  32'(trials[4]), 32'h58);
      check("done_busy",   32'(busy),   32'd0);
      @(negedge clk);
      check("b2b_busy", 32'(busy),     32'd1);
      check("b2b_dac",  32'(dac_code), 32'h80);
      check("b2b_valid",32'(sample_valid), 32'd0);

      // ADC_sel dropped mid-SETTLE
      repeat (2) @(negedge clk);
      ADC_sel = 2'd0;
      @(negedge clk);
      check("idle_dac",    32'(dac_code),     32'h0);
      check("idle_busy",   32'(busy),         32'd0);
      check("idle_sample", 32'(sample),       32'h5A);
      check("idle_valid",  32'(sample_valid), 32'd0);

      // Ramp on channel 2
      successive_approx = 1'b0; half = 1'b0; thr = 8'h03; ADC_sel = 2'd2;
      wait_start();
      check("ramp_start_dac", 32'(dac_code), 32'h0);
      run_to_valid(100, c);
      check("ramp_latency", 32'(c),      32'd21);
      check("ramp_sample",  32'(sample), 32'h03);

      // Mode toggled at the third SAR DECIDE
      ADC_sel = 2'd0;
      repeat (2) @(negedge clk);
      successive_approx = 1'b1; half = 1'b1; thr = 8'h5A; ADC_sel = 2'd1;
      wait_start();
      nval = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (sample_valid) nval++;
      end
      check("tog_decide_dac", 32'(dac_code), 32'h60);
      successive_approx = 1'b0; half = 1'b0; thr = 8'h02;
      @(negedge clk);
      check("tog_busy",   32'(busy),         32'd1);
      check("tog_dac",    32'(dac_code),     32'h0);
      check("tog_valid",  32'(sample_valid), 32'd0);
      check("tog_sample", 32'(sample),       32'h03);
      check("tog_nvalid", 32'(nval),         32'd0);
      run_to_valid(100, c);
      check("tog_ramp_latency", 32'(c),      32'd16);
      check("tog_ramp_sample",  32'(sample), 32'h02);

      // Ramp with comparator stuck high
      ADC_sel = 2'd0;
      repeat (2) @(negedge clk);
      stuck = 1'b1; ADC_sel = 2'd2;
      wait_start();
      run_to_valid(2000, c);
      check("stuck_latency", 32'(c),        32'd1281);
      check("stuck_sample",  32'(sample),   32'hFF);
      check("stuck_wraps",   32'(wraps),    32'd0);
      check("stuck_dac",     32'(dac_code), 32'hFF);

      // Reset in the middle of a SAR conversion
      stuck = 1'b0; successive_approx = 1'b1; half = 1'b1; thr = 8'h5A;
      repeat (10) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rst2_dac",    32'(dac_code),     32'h0);
      check("rst2_sample", 32'(sample),       32'h0);
      check("rst2_valid",  32'(sample_valid), 32'h0);
      check("rst2_busy",   32'(busy),         32'h0);
      reset = 1'b0;
`endif
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_conv_ctrl.md
# adc_conv_ctrl

Conversion controller that acts on the ADC mode selected by the menu. It reads `ADC_sel` and `successive_approx` and drives a PWM-DAC code against an external analog comparator. It runs either ramp or successive-approximation conversions back-to-back and presents each result with a one-cycle valid strobe to the output-select mux.

## Interface
- `DATA_WIDTH`, 8: DAC code and result width.
- `SETTLE_CYCLES`, 255: cycles the DAC/RC filter settles per trial code; must be ≥ 4.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ADC_sel` in 2: channel select from the menu. 0 = none, 1 = comparator 0, 2 = comparator 1, 3 = treated as 0.
- `successive_approx` in 1: conversion mode from the menu. 1 = SAR, 0 = ramp.
- `comp_in` in 2: asynchronous comparator outputs. 1 means analog input > DAC voltage.
- `dac_code` out DATA_WIDTH: trial code to the PWM DAC.
- `sample` out DATA_WIDTH: last completed result.
- `sample_valid` out 1: one-cycle pulse when `sample` updates.
- `busy` out 1: high while a conversion is in progress.

## Operation
- `comp_in` passes through a 2-flop synchronizer per bit. The selected synchronized bit is `cmp`.
- States: IDLE, START, SETTLE, DECIDE, DONE.
  - IDLE: `dac_code` = 0 and `busy` = 0. Go to START when `ADC_sel` ∈ {1,2}.
  - START (1 cycle): clear the working register.
    - SAR: load trial = MSB set.
    - Ramp: load trial = 0.
  - SETTLE: hold `dac_code` = trial for SETTLE_CYCLES cycles, then go to DECIDE.
  - DECIDE (1 cycle): sample `cmp`.
    - SAR: if `cmp` = 1, keep the current bit, otherwise clear it.
      - Not yet at LSB: set the next lower bit and return to SETTLE.
      - At LSB: go to DONE.
    - Ramp: if `cmp` = 0, result = trial and go to DONE.
      - Else if trial = all-ones, result = all-ones and go to DONE.
      - Else trial + 1 and return to SETTLE.
  - DONE (1 cycle): load `sample`, pulse `sample_valid`, then go to START. Conversions are continuous.
- Mode change: any change of `ADC_sel` or `successive_approx` outside IDLE aborts the conversion.
  - The next cycle is START, or IDLE if `ADC_sel` is now 0/3.
  - No `sample_valid` is produced and `sample` is unchanged.
  - The synchronizers are not cleared.
- A change that lands in the same cycle as DONE is still a change: DONE completes normally, then the abort applies.
- `busy` = 1 in START, SETTLE and DECIDE. It is 0 in IDLE and DONE.
- All arithmetic is unsigned DATA_WIDTH. Ramp increment never wraps, because all-ones terminates the conversion.

## Timing
- Reset values:
  - state = IDLE
  - `dac_code` = 0
  - `sample` = 0
  - `sample_valid` = 0
  - `busy` = 0
  - synchronizers = 0
  - settle counter = 0
- Reset mid-conversion returns to IDLE on the next edge. No `sample_valid` is produced.
- Step time is SETTLE_CYCLES + 1 cycles.
- SAR: START to `sample_valid` = 1 + DATA_WIDTH·(SETTLE_CYCLES+1) cycles, independent of input.
- Ramp, result k: 1 + (k+1)·(SETTLE_CYCLES+1) cycles.
- Comparator latency is 2 cycles through the synchronizer. Because SETTLE_CYCLES ≥ 4, `cmp` reflects the current trial code at DECIDE.
- `sample` changes only on the cycle `sample_valid` rises. It is stable at all other times.
- Back-to-back conversions: the DONE→START gap is 0 cycles.

## Configuration
- `ADC_AVG_EN` defined:
  - Raw results accumulate into a DATA_WIDTH+2 adder.
  - Every 4th DONE loads `sample` = sum >> 2 (truncating), pulses `sample_valid`, and clears the accumulator.
  - An abort or reset clears the accumulator and the 2-bit count.
- `ADC_AVG_EN` undefined: every DONE loads the raw result and pulses `sample_valid`.

## Test plan
All scenarios use DATA_WIDTH = 8 and SETTLE_CYCLES = 4, with `ADC_AVG_EN` undefined unless stated.
- SAR, `ADC_sel` = 1, comparator model threshold 0x5A (`cmp` = input > `dac_code`):
  - `sample` = 0x5A.
  - `sample_valid` occurs 41 cycles after START.
  - The SAR trial sequence starts 0x80, 0x40, 0x60, 0x50, 0x58, ...
- Ramp, `ADC_sel` = 2, threshold 0x03:
  - `sample` = 0x03.
  - `sample_valid` occurs 21 cycles after START.
- Ramp with the comparator stuck at 1:
  - `sample` = 0xFF after 1281 cycles.
  - `dac_code` never wraps to 0 mid-conversion.
- Toggle `successive_approx` at the 3rd DECIDE of a SAR conversion:
  - No `sample_valid` for that conversion.
  - `sample` keeps its prior value.
  - The next cycle is START with trial 0x00 (ramp).
- Set `ADC_sel` = 0 mid-SETTLE:
  - IDLE next cycle, with `dac_code` = 0 and `busy` = 0.
  - Assert `reset` mid-SAR: all outputs read the reset values one cycle later.
- With `ADC_AVG_EN` defined, SAR thresholds 0x10, 0x11, 0x12, 0x14:
  - A single `sample_valid` after the 4th DONE.
  - `sample` = 0x11 (0x47 >> 2).
